mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the core's single shared instruction/data memory port. It takes requests from the fetch stage (read-only) and the memory stage (load/store) and grants the port to one requester per cycle. Optionally, a read-modify-write lock keeps the port on the data side across several cycles. It drives the synchronous single-port RAM and routes each one-cycle-latency read response back to its owner. It sits between the pipeline stages and the shared memory array.

## Interface
- `ADDR_W`, 12: byte-address width; word index is `addr[ADDR_W-1:2]`.
- `XLEN`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive fetch denials before fetch is forced ahead of data (only with `ARB_STARVE_GUARD_EN`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  fetch read request.
- `i_addr`  in  ADDR_W  fetch byte address.
- `i_gnt`  out  1  fetch granted this cycle (combinational).
- `i_rvalid`  out  1  fetch read data valid.
- `i_rdata`  out  XLEN  fetch read data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  XLEN  store data.
- `d_wstrb`  in  4  store byte enables.
- `d_lock`  in  1  hold the port for data after this grant.
- `d_gnt`  out  1  data granted this cycle (combinational).
- `d_rvalid`  out  1  data response valid (loads, and errored stores).
- `d_rdata`  out  XLEN  load data.
- `d_err`  out  1  misaligned access, qualified by `d_rvalid`.
- `mem_en`  out  1  RAM access enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W-2  RAM word index.
- `mem_wdata`  out  XLEN  RAM write data.
- `mem_wstrb`  out  4  RAM byte enables.
- `mem_rdata`  in  XLEN  RAM read data, valid one cycle after a read access.
- `conflict_cnt`  out  32  count of cycles with both `i_req` and `d_req` high.

## Operation
- State machine with two states, `IDLE` and `LOCKED`.
- `IDLE` priority order:
  - If the starvation guard is active, fetch wins.
  - Otherwise data wins over fetch.
  - Exactly one grant per cycle, or none.
- A data grant with `d_lock=1` moves to `LOCKED`.
- In `LOCKED`:
  - Only data is granted; `i_gnt=0` regardless of the guard.
  - A cycle with `d_req=1, d_lock=0` is granted, then the state returns to `IDLE`.
  - A cycle with `d_req=0` holds `LOCKED`; no access is made.
- Misaligned data access (`d_addr[1:0]!=0`):
  - Granted, but `mem_en=0`.
  - Next cycle: `d_rvalid=1`, `d_err=1`, `d_rdata=0`.
  - Still consumes one arbitration slot.
  - Lock state transitions apply as for a normal grant.
- Fetch addresses are not checked; `i_addr[1:0]` is ignored.
- Memory outputs are a combinational mux of the granted requester. With no grant: `mem_en=0` and all other memory outputs are 0.
- Response routing: a registered owner tag (NONE/I/D plus error flag) is captured on each grant.
  - Owner I: `i_rvalid=1`, `i_rdata=mem_rdata`.
  - Owner D, load: `d_rvalid=1`, `d_rdata=mem_rdata`.
  - Correct stores produce no response.
  - `rdata` outputs are 0 when their `rvalid` is 0.
- `conflict_cnt` increments on every cycle with both requests high, in any state, and wraps from 2^32-1 to 0.

## Timing
- Grant and memory-port outputs are combinational in the same cycle as the request.
- Read latency is exactly 1 cycle: `rvalid` is registered in the cycle after the grant.
- Back-to-back grants are allowed every cycle; no bubbles are inserted.
- A request must be held until granted. Dropping an ungranted request is legal and has no side effect.
- Reset values: state `IDLE`, owner NONE, `i_rvalid=d_rvalid=d_err=0`, `conflict_cnt=0`, starvation counter 0.
- With `rst` high, all grants and `mem_en` are 0.
- Reset during `LOCKED` or with a response in flight discards the response; no `rvalid` follows reset release.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 3-bit saturating counter increments on each cycle with `i_req=1, i_gnt=0`, and clears on `i_gnt`.
  - When the counter is ≥ `STARVE_LIMIT` in `IDLE`, fetch is granted over data.
- `ARB_STARVE_GUARD_EN` undefined:
  - Strict data priority; no counter is built.
  - `STARVE_LIMIT` is unused.

## Structure
- Shared package `core_pkg` holds:
  - `XLEN` and memory constants.
  - the `arb_state_t` enum (`IDLE`, `LOCKED`).
  - the `arb_owner_t` enum (`NONE`, `I`, `D`).
- One sub-module, `starve_counter`, holds the saturating counter and threshold compare; it is instantiated only under the macro.

## Test plan
- Fetch alone: `i_req`, `i_addr=0x10` → `i_gnt=1`, `mem_addr=4`. Next cycle `i_rvalid=1`, `i_rdata` = RAM word 4.
- Simultaneous load `d_addr=0x20` and fetch → `d_gnt=1`, `i_gnt=0`, `conflict_cnt=1`. Next cycle `d_rvalid=1` and fetch is granted.
- Store `d_addr=0x8`, `d_wstrb=4'b0011`, `d_wdata=0xAABBCCDD` → `mem_we=1`, `mem_wstrb=0011`, no `d_rvalid`. A load of `0x8` then returns the low half updated.
- Lock: load with `d_lock=1`, then 2 idle cycles, then a store with `d_lock=0`, while fetch requests throughout → `i_gnt=0` for all 4 cycles; fetch granted the cycle after the store.
- Misaligned load `d_addr=0x22` → `mem_en=0`; next cycle `d_rvalid=1`, `d_err=1`.
- With `ARB_STARVE_GUARD_EN`, `STARVE_LIMIT=4`, continuous data and fetch requests → fetch granted on the 5th cycle, then the counter clears. Without the macro, fetch is never granted.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core constants and the memory-port arbiter state/owner types.
package core_pkg;
    localparam int XLEN         = 32;
    localparam int WORD_OFF     = 2;
    localparam int STARVE_CNT_W = 3;

    typedef enum logic {IDLE, LOCKED} arb_state_t;
    typedef enum logic [1:0] {NONE, I, D} arb_owner_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of consecutive fetch denials, flagged at LIMIT.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic starve
);
    import core_pkg::*;

    logic [STARVE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (i_gnt) cnt <= '0;
        else if (i_req && !(&cnt)) cnt <= cnt + 1'b1;
    end

    assign starve = int'(cnt) >= LIMIT;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for the shared single-port RAM with 1-cycle read routing.
// Defining ARB_STARVE_GUARD_EN adds a fetch starvation guard; otherwise data has strict priority.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int XLEN         = core_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [3:0]        d_wstrb,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [31:0]       conflict_cnt
);
    import core_pkg::*;

    arb_state_t state, next_state;
    arb_owner_t owner, next_owner;
    logic       err_q, next_err, guard, d_mis, d_acc;
    logic       unused_bits;

    assign unused_bits = ^{i_addr[WORD_OFF-1:0], STARVE_LIMIT};
    assign d_mis       = d_addr[WORD_OFF-1:0] != '0;

`ifdef ARB_STARVE_GUARD_EN
    logic starve;
    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .i_gnt  (i_gnt),
        .starve (starve)
    );
    assign guard = starve && state == IDLE;
`else
    assign guard = 1'b0;
`endif

    always_comb begin
        next_state = state;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        if (!rst && state == LOCKED) begin
            d_gnt      = d_req;
            next_state = (d_req && !d_lock) ? IDLE : LOCKED;
        end else if (!rst) begin
            i_gnt      = i_req && (guard || !d_req);
            d_gnt      = d_req && !i_gnt;
            next_state = (d_gnt && d_lock) ? LOCKED : IDLE;
        end
    end

    // Misaligned data grants take the slot but never touch the RAM.
    assign d_acc     = d_gnt && !d_mis;
    assign mem_en    = i_gnt || d_acc;
    assign mem_we    = d_acc && d_we;
    assign mem_addr  = i_gnt ? i_addr[ADDR_W-1:WORD_OFF] : d_acc ? d_addr[ADDR_W-1:WORD_OFF] : '0;
    assign mem_wdata = d_acc ? d_wdata : '0;
    assign mem_wstrb = d_acc ? d_wstrb : '0;

    assign next_owner = i_gnt ? I : (d_gnt && (d_mis || !d_we)) ? D : NONE;
    assign next_err   = d_gnt && d_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= NONE;
            err_q        <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state        <= next_state;
            owner        <= next_owner;
            err_q        <= next_err;
            conflict_cnt <= conflict_cnt + 32'(i_req && d_req);
        end
    end

    assign i_rvalid = owner == I;
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rvalid = owner == D;
    assign d_err    = d_rvalid && err_q;
    assign d_rdata  = (d_rvalid && !err_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a behavioural RAM.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [11:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [11:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] conflict_cnt;
    logic [31:0] ram [0:1023];
    int pass = 0, total = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 1024; k++) ram[k] = 32'hA000_0000 | k;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_req = 1'b1; d_req = 1'b1;
        #1;
        total++; if (i_gnt !== 1'b0) $display("FAIL reset_i_gnt got %b want 0", i_gnt); else pass++;
        total++; if (d_gnt !== 1'b0) $display("FAIL reset_d_gnt got %b want 0", d_gnt); else pass++;
        total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got %b want 0", mem_en); else pass++;
        total++; if ({i_rvalid, d_rvalid, d_err} !== 3'b000) $display("FAIL reset_rvalid got %b want 000", {i_rvalid, d_rvalid, d_err}); else pass++;
        step();
        total++; if (conflict_cnt !== 32'd0) $display("FAIL reset_conflict got %0d want 0", conflict_cnt); else pass++;
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk) rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 12'h010;
        #1;
        total++; if ({i_gnt, d_gnt, mem_en} !== 3'b101) $display("FAIL fetch_gnt got %b want 101", {i_gnt, d_gnt, mem_en}); else pass++;
        total++; if (mem_addr !== 10'd4) $display("FAIL fetch_addr got %0d want 4", mem_addr); else pass++;
        step();
        i_req = 1'b0;
        #1;
        total++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0004) $display("FAIL fetch_rdata got %b/%h want 1/a0000004", i_rvalid, i_rdata); else pass++;
        total++; if (d_rvalid !== 1'b0) $display("FAIL fetch_d_rvalid got %b want 0", d_rvalid); else pass++;
        step();
    endtask

    task automatic test_conflict();
        i_req = 1'b1; i_addr = 12'h014; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
        #1;
        total++; if ({d_gnt, i_gnt} !== 2'b10) $display("FAIL conflict_gnt got %b want 10", {d_gnt, i_gnt}); else pass++;
        total++; if (mem_addr !== 10'd8) $display("FAIL conflict_addr got %0d want 8", mem_addr); else pass++;
        step();
        d_req = 1'b0;
        #1;
        total++; if (conflict_cnt !== 32'd1) $display("FAIL conflict_cnt got %0d want 1", conflict_cnt); else pass++;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA000_0008) $display("FAIL conflict_load got %b/%h want 1/a0000008", d_rvalid, d_rdata); else pass++;
        total++; if (i_gnt !== 1'b1 || mem_addr !== 10'd5) $display("FAIL conflict_fetch got %b/%0d want 1/5", i_gnt, mem_addr); else pass++;
        step();
        i_req = 1'b0;
        #1;
        total++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0005 || d_rvalid !== 1'b0) $display("FAIL conflict_fetch_rsp got %b/%h/%b want 1/a0000005/0", i_rvalid, i_rdata, d_rvalid); else pass++;
        step();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h008; d_wdata = 32'hAABB_CCDD; d_wstrb = 4'b0011;
        #1;
        total++; if ({mem_en, mem_we, mem_wstrb} !== 6'b110011) $display("FAIL store_ctl got %b want 110011", {mem_en, mem_we, mem_wstrb}); else pass++;
        total++; if (mem_addr !== 10'd2 || mem_wdata !== 32'hAABB_CCDD) $display("FAIL store_data got %0d/%h want 2/aabbccdd", mem_addr, mem_wdata); else pass++;
        step();
        d_we = 1'b0;
        #1;
        total++; if (d_rvalid !== 1'b0) $display("FAIL store_no_rsp got %b want 0", d_rvalid); else pass++;
        step();
        d_req = 1'b0;
        #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA000_CCDD) $display("FAIL store_readback got %b/%h want 1/a000ccdd", d_rvalid, d_rdata); else pass++;
        step();
    endtask

    task automatic test_lock();
        i_req = 1'b1; i_addr = 12'h030;
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 12'h004;
        #1;
        total++; if ({d_gnt, i_gnt} !== 2'b10) $display("FAIL lock_c1 got %b want 10", {d_gnt, i_gnt}); else pass++;
        step();
        d_req = 1'b0; d_lock = 1'b0;
        #1;
        total++; if ({i_gnt, d_gnt, mem_en} !== 3'b000 || mem_addr !== 10'd0) $display("FAIL lock_c2 got %b/%0d want 000/0", {i_gnt, d_gnt, mem_en}, mem_addr); else pass++;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA000_0001) $display("FAIL lock_load got %b/%h want 1/a0000001", d_rvalid, d_rdata); else pass++;
        step();
        #1;
        total++; if ({i_gnt, d_rvalid} !== 2'b00) $display("FAIL lock_c3 got %b want 00", {i_gnt, d_rvalid}); else pass++;
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h00C; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
        #1;
        total++; if ({d_gnt, i_gnt, mem_we} !== 3'b101) $display("FAIL lock_c4 got %b want 101", {d_gnt, i_gnt, mem_we}); else pass++;
        step();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        total++; if (i_gnt !== 1'b1 || mem_addr !== 10'd12) $display("FAIL lock_release got %b/%0d want 1/12", i_gnt, mem_addr); else pass++;
        step();
        i_req = 1'b0;
        #1;
        total++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_000C) $display("FAIL lock_fetch_rsp got %b/%h want 1/a000000c", i_rvalid, i_rdata); else pass++;
        total++; if (conflict_cnt !== 32'd3) $display("FAIL lock_conflict got %0d want 3", conflict_cnt); else pass++;
        step();
    endtask

    task automatic test_misaligned();
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h022;
        #1;
        total++; if ({d_gnt, mem_en} !== 2'b10) $display("FAIL mis_gnt got %b want 10", {d_gnt, mem_en}); else pass++;
        step();
        d_req = 1'b0;
        #1;
        total++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'd0) $display("FAIL mis_rsp got %b/%h want 11/0", {d_rvalid, d_err}, d_rdata); else pass++;
        step();
        total++; if ({d_rvalid, d_err} !== 2'b00) $display("FAIL mis_clear got %b want 00", {d_rvalid, d_err}); else pass++;
    endtask

    task automatic test_starve();
        logic [5:0] want_i;
`ifdef ARB_STARVE_GUARD_EN
        want_i = 6'b010000;
`else
        want_i = 6'b000000;
`endif
        i_req = 1'b1; i_addr = 12'h040; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h000;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++;
            if ({i_gnt, d_gnt} !== {want_i[c], !want_i[c]})
                $display("FAIL starve_c%0d got %b want %b", c + 1, {i_gnt, d_gnt}, {want_i[c], !want_i[c]});
            else pass++;
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        #1;
        total++; if (conflict_cnt !== 32'd9) $display("FAIL starve_conflict got %0d want 9", conflict_cnt); else pass++;
        step();
    endtask

    task automatic test_reset_inflight();
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 12'h004;
        step();
        d_req = 1'b0; d_lock = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (d_rvalid !== 1'b0 || conflict_cnt !== 32'd0) $display("FAIL rst_inflight got %b/%0d want 0/0", d_rvalid, conflict_cnt); else pass++;
        @(negedge clk) rst = 1'b0;
        step();
        i_req = 1'b1; i_addr = 12'h000;
        #1;
        total++; if ({d_rvalid, i_gnt} !== 2'b01) $display("FAIL rst_unlock got %b want 01", {d_rvalid, i_gnt}); else pass++;
        step();
        i_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_lock();
        test_misaligned();
        test_starve();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
